// File: rtl/tdm_pkg.sv
// ============================================================================
// Module : tdm_pkg
// Brief  : Shared constants for the TDM transmitter / receiver pair.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tdm_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Bit order on the wire within a slot; the transmitter serialises the same way.
  localparam bit SLOT_MSB_FIRST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tdm_deser.sv
// ============================================================================
// Module : tdm_deser
// Brief  : Slot shift register plus bit counter for the TDM receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tdm_deser
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             shift,
  input  logic             start,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic [BW-1:0]    bit_cnt
);

  localparam logic [BW-1:0] c_LAST_BIT = BW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sreg;
  logic [BW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_first;

  // w_first loads a fresh slot with din as its first wire bit, discarding old contents.
  generate
    if (SLOT_MSB_FIRST) begin : g_msb_first
      assign w_next  = {r_sreg[WIDTH-2:0], din};
      assign w_first = {{(WIDTH-1){1'b0}}, din};
    end else begin : g_lsb_first
      assign w_next  = {din, r_sreg[WIDTH-1:1]};
      assign w_first = {din, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (start) begin
      r_sreg <= w_first;
      r_cnt  <= BW'(1);
    end else if (shift) begin
      r_sreg <= w_next;
      r_cnt  <= (r_cnt == c_LAST_BIT) ? '0 : r_cnt + 1'b1;
    end
  end

  assign word      = w_next;
  assign word_done = shift && (r_cnt == c_LAST_BIT);
  assign bit_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/tdm_demux_4ch.sv
// ============================================================================
// Module : tdm_demux_4ch
// Brief  : Serial TDM receiver: frame lock FSM, slot counter, channel registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [NCH*WIDTH-1:0] ch_data,
  output logic [NCH-1:0]       ch_valid,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] c_LAST_SLOT = CW'(NCH - 1);

  logic [0:0]           r_state;
  logic [CW-1:0]        r_slot;
  logic [NCH*WIDTH-1:0] r_ch_data;
  logic [NCH-1:0]       r_ch_valid;
  logic                 r_frame_done;
  logic                 r_sync_err;

  logic [0:0]           w_next_state;
  logic                 w_shift;
  logic                 w_start;
  logic                 w_clear;
  logic                 w_err;
  logic                 w_at_start;
  logic [WIDTH-1:0]     w_word;
  logic                 w_word_done;
  logic [BW-1:0]        w_bit_cnt;

  tdm_deser #(
    .WIDTH (WIDTH),
    .BW    (BW)
  ) u_deser (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .shift     (w_shift),
    .start     (w_start),
    .clear     (w_clear),
    .word      (w_word),
    .word_done (w_word_done),
    .bit_cnt   (w_bit_cnt)
  );

  assign w_at_start = (r_slot == '0) && (w_bit_cnt == '0);

  // A sync anywhere but the frame start re-aligns; a missing sync at frame start drops lock.
  always_comb begin
    w_next_state = r_state;
    w_shift      = 1'b0;
    w_start      = 1'b0;
    w_clear      = 1'b0;
    w_err        = 1'b0;
    if (din_valid) begin
      if (r_state == ST_HUNT) begin
        if (frame_sync) begin
          w_start      = 1'b1;
          w_next_state = ST_LOCKED;
        end
      end else if (frame_sync && !w_at_start) begin
        w_start = 1'b1;
        w_err   = 1'b1;
      end else if (!frame_sync && w_at_start) begin
        w_clear      = 1'b1;
        w_err        = 1'b1;
        w_next_state = ST_HUNT;
      end else begin
        w_shift = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_HUNT;
      r_slot       <= '0;
      r_ch_data    <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_sync_err   <= w_err;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      if (w_start) begin
        r_slot <= '0;
      end else if (w_word_done) begin
        r_ch_data[r_slot*WIDTH +: WIDTH] <= w_word;
        r_ch_valid[r_slot]               <= 1'b1;
        r_frame_done                     <= (r_slot == c_LAST_SLOT);
        r_slot <= (r_slot == c_LAST_SLOT) ? '0 : r_slot + 1'b1;
      end
    end
  end

  assign ch_data    = r_ch_data;
  assign ch_valid   = r_ch_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = (r_state == ST_LOCKED);

endmodule

`default_nettype wire

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per channel slot.
REQ-002 SHALL have parameter NCH, default 4: channel slots per frame.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have port din, input, 1: serial TDM data, MSB of each slot first.
REQ-006 SHALL have port din_valid, input, 1: qualifies din and frame_sync for the current cycle.
REQ-007 SHALL have port frame_sync, input, 1: marks the first bit (MSB) of slot 0.
REQ-008 SHALL have port ch_data, output, NCH*WIDTH: registered channel words; slot k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port ch_valid, output, NCH: one-cycle pulse per slot when its word updates.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse when slot NCH-1 completes.
REQ-011 SHALL have port locked, output, 1: high in LOCKED state.
REQ-012 SHALL have port sync_err, output, 1: one-cycle pulse on a framing violation.

Function
REQ-013 SHALL implement states HUNT and LOCKED; the FSM SHALL act only in cycles with din_valid=1. With din_valid=0, counters, shift register and state SHALL hold.
REQ-014 In HUNT, din SHALL be ignored until din_valid=1 and frame_sync=1. That bit SHALL be taken as slot 0 bit WIDTH-1, and the FSM SHALL enter LOCKED.
REQ-015 In LOCKED, each valid bit SHALL shift into a WIDTH-bit shift register (MSB first) and increment bit_cnt. bit_cnt SHALL wrap from WIDTH-1 to 0.
REQ-016 On the last bit of slot k, the assembled word SHALL be written to ch_data slot k, and ch_valid[k] SHALL pulse high. Both SHALL be visible the cycle after the last bit is sampled (latency 1). slot_cnt SHALL then advance and wrap from NCH-1 to 0.
REQ-017 frame_done SHALL pulse in the same cycle as ch_valid[NCH-1].
REQ-018 If frame_sync=1 while LOCKED at any position other than slot 0 bit 0:
- sync_err SHALL pulse;
- the partial word SHALL be discarded, with no ch_valid;
- the current bit SHALL be taken as slot 0 MSB;
- the FSM SHALL stay in LOCKED.
REQ-019 If frame_sync=0 at the expected slot 0 bit 0 position, sync_err SHALL pulse and the FSM SHALL enter HUNT. That bit SHALL be discarded.
REQ-020 ch_data slots not being written SHALL hold their previous values; at most one ch_valid bit SHALL be high per cycle.
REQ-021 frame_sync with din_valid=0 SHALL be ignored.

Reset
REQ-022 With rst=1 at a clock edge:
- state SHALL be HUNT;
- bit_cnt, slot_cnt and the shift register SHALL be 0;
- ch_data, ch_valid, frame_done, locked and sync_err SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no ch_valid pulse, and SHALL take precedence over all other inputs.

Structure
REQ-024 The HUNT/LOCKED encodings, default WIDTH/NCH and the slot bit-ordering constant SHALL live in shared package tdm_pkg, which the matching TDM transmitter also uses.
REQ-025 The shift register plus bit counter SHALL be a sub-module tdm_deser (outputs: word, word_done); the FSM, slot counter and output registers SHALL reside in the top level.

Verification
REQ-026 Reset then idle: rst=1 for 2 cycles, then din_valid=0 for 10 cycles -> all outputs 0, locked=0.
REQ-027 Clean frame: frame_sync on the first bit, serial 0xA5, 0x3C, 0xFF, 0x01, contiguous valid -> ch_valid[0..3] pulse in turn. Afterwards ch_data=0x01FF3CA5, with frame_done coincident with ch_valid[3] and locked=1 from cycle 2.
REQ-028 Stalled input: same frame with din_valid=0 inserted every other cycle -> identical ch_data; each ch_valid pulse exactly 1 cycle wide.
REQ-029 Early sync: frame_sync reasserted at slot 2 bit 3 -> sync_err pulse, no ch_valid[2], locked stays 1. The next 32 bits are decoded as a new frame.
REQ-030 Missing sync: second frame sent without frame_sync -> sync_err at slot 0 bit 0, locked=0, and ch_data holds the first-frame values.
REQ-031 Reset mid-frame: rst=1 at slot 1 bit 4 -> next cycle all outputs 0, HUNT, and no ch_valid pulse.
